// File: rtl/mapped_ram_pkg.sv
// ============================================================================
// mapped_ram_pkg -- register offsets and sequencer states for mapped_ram
// Rev 1.0
// ============================================================================
`default_nettype none

package mapped_ram_pkg;

  localparam int unsigned REG_WREG  = 0;
  localparam int unsigned REG_CARRY = 1;
  localparam int unsigned REG_ZERO  = 2;
  localparam int unsigned REG_INDV  = 3;
  localparam int unsigned REG_INDA  = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mapped_ram_store.sv
// ============================================================================
// mapped_ram_store -- single-port word storage, sync write, registered read
// Rev 1.0
// ============================================================================
`default_nettype none

module mapped_ram_store #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/mapped_ram.sv
// ============================================================================
// mapped_ram -- zero-filled word RAM with a small CPU register window
// Optional: MAPPED_RAM_AUTOINC_EN makes INDA post-increment on INDV access.
// Rev 1.0
// ============================================================================
`default_nettype none

module mapped_ram
  import mapped_ram_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 512,
  parameter int REG_BASE = 'h200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic [DATA_W-1:0] wreg_in,
  input  logic              zero_in,
  input  logic              carry_in,
  output logic              carry_out,
  output logic              carry_we,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] A_WREG  = ADDR_W'(REG_BASE + REG_WREG);
  localparam logic [ADDR_W-1:0] A_CARRY = ADDR_W'(REG_BASE + REG_CARRY);
  localparam logic [ADDR_W-1:0] A_ZERO  = ADDR_W'(REG_BASE + REG_ZERO);
  localparam logic [ADDR_W-1:0] A_INDV  = ADDR_W'(REG_BASE + REG_INDV);
  localparam logic [ADDR_W-1:0] A_INDA  = ADDR_W'(REG_BASE + REG_INDA);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  fill_q, fill_d;
  logic [IDX_W-1:0]  inda_q, inda_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_store_q, rsp_store_d;
  logic [DATA_W-1:0] rsp_reg_q, rsp_reg_d;
  logic              carry_out_q, carry_out_d;
  logic              carry_we_q, carry_we_d;

  logic              accept;
  logic              hit_store;
  logic              hit_indv;
  logic              st_we;
  logic              st_re;
  logic [IDX_W-1:0]  st_addr;
  logic [DATA_W-1:0] st_wdata;
  logic [DATA_W-1:0] st_rdata;

  always_comb begin
    accept      = (state_q == ST_IDLE) && req_valid;
    hit_store   = {1'b0, req_addr} < DEPTH_LIM;
    hit_indv    = (req_addr == A_INDV);
    state_d     = state_q;
    fill_d      = fill_q;
    inda_d      = inda_q;
    rsp_valid_d = accept && !req_we;
    rsp_store_d = rsp_store_q;
    rsp_reg_d   = rsp_reg_q;
    carry_out_d = carry_out_q;
    carry_we_d  = 1'b0;
    st_we       = 1'b0;
    st_re       = 1'b0;
    st_addr     = hit_indv ? inda_q : req_addr[IDX_W-1:0];
    st_wdata    = req_wdata;

    if (state_q == ST_INIT) begin
      st_we    = 1'b1;
      st_addr  = fill_q;
      st_wdata = '0;
      fill_d   = fill_q + IDX_W'(1);
      if (fill_q == IDX_W'(DEPTH - 1)) begin
        state_d = ST_IDLE;
      end
    end else if (accept) begin
      st_we = req_we && (hit_store || hit_indv);
      st_re = !req_we && (hit_store || hit_indv);
      if (!req_we) begin
        rsp_store_d = hit_store || hit_indv;
        // Register reads are captured here so wreg/flag inputs are sampled at acceptance
        if (req_addr == A_WREG) begin
          rsp_reg_d = wreg_in;
        end else if (req_addr == A_CARRY) begin
          rsp_reg_d = DATA_W'(carry_in);
        end else if (req_addr == A_ZERO) begin
          rsp_reg_d = DATA_W'(zero_in);
        end else if (req_addr == A_INDA) begin
          rsp_reg_d = DATA_W'(inda_q);
        end else begin
          rsp_reg_d = '0;
        end
      end
      if (req_we && req_addr == A_CARRY) begin
        carry_out_d = req_wdata[0];
        carry_we_d  = 1'b1;
      end
      if (req_we && req_addr == A_INDA) begin
        inda_d = req_wdata[IDX_W-1:0];
      end
`ifdef MAPPED_RAM_AUTOINC_EN
      if (hit_indv) begin
        inda_d = inda_q + IDX_W'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      fill_q      <= '0;
      inda_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_store_q <= 1'b0;
      rsp_reg_q   <= '0;
      carry_out_q <= 1'b0;
      carry_we_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      inda_q      <= inda_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_store_q <= rsp_store_d;
      rsp_reg_q   <= rsp_reg_d;
      carry_out_q <= carry_out_d;
      carry_we_q  <= carry_we_d;
    end
  end

  mapped_ram_store #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_store (
    .clk   (clk),
    .we    (st_we),
    .re    (st_re),
    .addr  (st_addr),
    .wdata (st_wdata),
    .rdata (st_rdata)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_INIT);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_store_q ? st_rdata : rsp_reg_q;
  assign carry_out = carry_out_q;
  assign carry_we  = carry_we_q;

endmodule

`default_nettype wire

// File: tb/tb_mapped_ram.sv
// ============================================================================
// tb_mapped_ram -- self-checking bench for mapped_ram (default parameters)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mapped_ram;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [9:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [15:0] wreg_in;
  logic        zero_in;
  logic        carry_in;
  logic        carry_out;
  logic        carry_we;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] mem_m [DEPTH];
  int unsigned inda_m;
  logic        carry_m;

  always #5 clk = ~clk;

  mapped_ram dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .wreg_in   (wreg_in),
    .zero_in   (zero_in),
    .carry_in  (carry_in),
    .carry_out (carry_out),
    .carry_we  (carry_we),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 16'h0000;
    inda_m  = 0;
    carry_m = 1'b0;
  endtask

  function automatic void bump_inda();
`ifdef MAPPED_RAM_AUTOINC_EN
    inda_m = (inda_m + 1) % DEPTH;
`endif
  endfunction

  function automatic logic [15:0] model_read(input logic [9:0] a);
    logic [15:0] v;
    v = 16'h0000;
    if (a < 10'h200) v = mem_m[int'(a)];
    else if (a == 10'h200) v = wreg_in;
    else if (a == 10'h201) v = {15'b0, carry_in};
    else if (a == 10'h202) v = {15'b0, zero_in};
    else if (a == 10'h203) begin
      v = mem_m[inda_m];
      bump_inda();
    end
    else if (a == 10'h204) v = 16'(inda_m);
    return v;
  endfunction

  function automatic bit model_write(input logic [9:0] a, input logic [15:0] d);
    bit is_carry;
    is_carry = 1'b0;
    if (a < 10'h200) mem_m[int'(a)] = d;
    else if (a == 10'h201) begin
      carry_m  = d[0];
      is_carry = 1'b1;
    end
    else if (a == 10'h203) begin
      mem_m[inda_m] = d;
      bump_inda();
    end
    else if (a == 10'h204) inda_m = int'(d) % DEPTH;
    return is_carry;
  endfunction

  task automatic rd(input logic [9:0] a, input string tag, output logic [15:0] obs);
    logic [15:0] exp;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    exp       = model_read(a);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check(tag, 32'(rsp_rdata), 32'(exp));
    obs = rsp_rdata;
  endtask

  task automatic wr(input logic [9:0] a, input logic [15:0] d, input string tag);
    bit is_carry;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    is_carry  = model_write(a, d);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_norsp"}, 32'(rsp_valid), 32'd0);
    check({tag, "_cwe"}, 32'(carry_we), 32'(is_carry));
    if (is_carry) begin
      check({tag, "_cout"}, 32'(carry_out), 32'(carry_m));
      @(negedge clk);
      check({tag, "_cwe_end"}, 32'(carry_we), 32'd0);
      check({tag, "_cout_hold"}, 32'(carry_out), 32'(carry_m));
    end
  endtask

  task automatic wait_fill(output int n);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] obs;
    int          n;
    logic [9:0]  a;
    int          sel;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    wreg_in   = '0;
    zero_in   = 1'b0;
    carry_in  = 1'b0;
    model_reset();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_carry_we", 32'(carry_we), 32'd0);
    check("rst_carry_out", 32'(carry_out), 32'd0);

    // Fill length and first read
    rst = 1'b0;
    wait_fill(n);
    check("fill_cycles", 32'(n), 32'd512);
    check("ready_after_fill", 32'(req_ready), 32'd1);
    rd(10'h1FF, "rd_1ff", obs);
    check("rd_1ff_zero", 32'(obs), 32'h0);

    // Plain storage
    wr(10'h000, 16'hDEAD, "wr0");
    wr(10'h001, 16'hBEEF, "wr1");
    rd(10'h001, "rd1", obs);
    check("rd1_const", 32'(obs), 32'hBEEF);
    rd(10'h000, "rd0", obs);
    check("rd0_const", 32'(obs), 32'hDEAD);
    @(negedge clk);
    check("rsp_valid_idle", 32'(rsp_valid), 32'd0);

    // Indirection
    wr(10'h204, 16'h0001, "wr_inda1");
    rd(10'h203, "rd_indv", obs);
    check("rd_indv_const", 32'(obs), 32'hBEEF);
    wr(10'h204, 16'hFFFF, "wr_inda_mask");
    rd(10'h204, "rd_inda", obs);
    check("rd_inda_const", 32'(obs), 32'h01FF);

    // CPU register window
    wreg_in  = 16'hC0DE;
    zero_in  = 1'b1;
    carry_in = 1'b0;
    rd(10'h200, "rd_wreg", obs);
    check("rd_wreg_const", 32'(obs), 32'hC0DE);
    rd(10'h202, "rd_zero", obs);
    check("rd_zero_const", 32'(obs), 32'h0001);
    rd(10'h201, "rd_carry", obs);
    check("rd_carry_const", 32'(obs), 32'h0000);
    wr(10'h201, 16'h0003, "wr_carry");
    check("carry_out_const", 32'(carry_out), 32'd1);
    wr(10'h200, 16'h5555, "wr_wreg_ign");
    rd(10'h200, "rd_wreg2", obs);
    rd(10'h205, "rd_unmapped", obs);
    check("rd_unmapped_const", 32'(obs), 32'h0);

    // Auto-increment behaviour
    wr(10'h204, 16'h01FF, "wr_inda_top");
    wr(10'h203, 16'h1234, "wr_indv_a");
    wr(10'h203, 16'h1234, "wr_indv_b");
    rd(10'h204, "rd_inda_ai", obs);
`ifdef MAPPED_RAM_AUTOINC_EN
    check("inda_ai_const", 32'(obs), 32'h0001);
`else
    check("inda_ai_const", 32'(obs), 32'h01FF);
`endif
    rd(10'h1FF, "rd_1ff_ai", obs);
    check("rd_1ff_ai_const", 32'(obs), 32'h1234);
    rd(10'h000, "rd_0_ai", obs);
`ifdef MAPPED_RAM_AUTOINC_EN
    check("rd_0_ai_const", 32'(obs), 32'h1234);
`else
    check("rd_0_ai_const", 32'(obs), 32'hDEAD);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 200; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 3)      a = 10'($urandom_range(0, 15));
      else if (sel < 5) a = 10'($urandom_range(0, 511));
      else if (sel < 9) a = 10'(32'h200 + $urandom_range(0, 7));
      else              a = 10'($urandom_range(32'h208, 32'h3FF));
      wreg_in  = 16'($urandom);
      zero_in  = 1'($urandom);
      carry_in = 1'($urandom);
      if ($urandom_range(0, 1) == 1) wr(a, 16'($urandom), "rnd_wr");
      else                           rd(a, "rnd_rd", obs);
    end

    // Reset during an outstanding read
    wr(10'h000, 16'hDEAD, "wr0_again");
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 10'h000;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_ready", 32'(req_ready), 32'd0);
    check("midrst_carry_out", 32'(carry_out), 32'd0);
    model_reset();
    rst = 1'b0;
    wait_fill(n);
    check("refill_cycles", 32'(n), 32'd512);
    rd(10'h000, "rd0_refill", obs);
    check("rd0_refill_const", 32'(obs), 32'h0);
    rd(10'h204, "rd_inda_refill", obs);
    check("rd_inda_refill_const", 32'(obs), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
